// File: rtl/hex_seg_driver.sv
// HEX display output stage: raw or hex-decoded segments with enable,
// 16-level PWM brightness, programmable blink and an Avalon-MM slave.
module hex_seg_driver #(
  parameter logic [23:0] BLINK_RESET    = 24'd12_499_999,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [6:0]  seg_in,
  output logic [6:0]  hex_n
);

  localparam logic [6:0] SEG_OFF =
    SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  logic        en_q, blink_en_q, decode_q;
  logic [3:0]  bright_q;
  logic [23:0] blink_q;
  logic [6:0]  seg_q, seg_d;
  logic [3:0]  pwm_cnt_q;
  logic [23:0] blink_cnt_q, blink_cnt_d;
  logic        phase_q, phase_d;
  logic [6:0]  hex_q, hex_d;
  logic        wr, wr_ctrl, wr_blink;
  logic        pwm_on;
  logic [6:0]  font;
  logic [6:0]  vis;

  assign wr       = chipselect & ~write_n;
  assign wr_ctrl  = wr & (address == 2'd0);
  assign wr_blink = wr & (address == 2'd1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_q       <= 1'b1;
      blink_en_q <= 1'b0;
      decode_q   <= 1'b0;
      bright_q   <= 4'hF;
      blink_q    <= BLINK_RESET;
    end else begin
      if (wr_ctrl) begin
        en_q       <= writedata[0];
        blink_en_q <= writedata[1];
        decode_q   <= writedata[2];
        bright_q   <= writedata[11:8];
      end
      if (wr_blink) begin
        blink_q <= writedata[23:0];
      end
    end
  end

  always_comb begin
    font = 7'h00;
    case (seg_in[3:0])
      4'h0: font = 7'h3F;
      4'h1: font = 7'h06;
      4'h2: font = 7'h5B;
      4'h3: font = 7'h4F;
      4'h4: font = 7'h66;
      4'h5: font = 7'h6D;
      4'h6: font = 7'h7D;
      4'h7: font = 7'h07;
      4'h8: font = 7'h7F;
      4'h9: font = 7'h6F;
      4'hA: font = 7'h77;
      4'hB: font = 7'h7C;
      4'hC: font = 7'h39;
      4'hD: font = 7'h5E;
      4'hE: font = 7'h79;
      4'hF: font = 7'h71;
      default: font = 7'h00;
    endcase
  end

  assign seg_d = decode_q ? font : seg_in;

  // A BLINK write restarts the sequence even on a terminal-count cycle.
  always_comb begin
    blink_cnt_d = blink_cnt_q + 24'd1;
    phase_d     = phase_q;
    if (wr_blink || !blink_en_q) begin
      blink_cnt_d = '0;
      phase_d     = 1'b1;
    end else if (blink_cnt_q == blink_q) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end
  end

  assign pwm_on = (pwm_cnt_q <= bright_q);
  assign vis    = seg_q & {7{en_q & phase_q & pwm_on}};
  assign hex_d  = SEG_ACTIVE_LOW ? ~vis : vis;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg_q       <= '0;
      pwm_cnt_q   <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
      hex_q       <= SEG_OFF;
    end else begin
      seg_q       <= seg_d;
      pwm_cnt_q   <= pwm_cnt_q + 4'd1;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      hex_q       <= hex_d;
    end
  end

  assign hex_n = hex_q;

  always_comb begin
    readdata = '0;
    case (address)
      2'd0: readdata = {20'd0, bright_q, 5'd0,
                        decode_q, blink_en_q, en_q};
      2'd1: readdata = {8'd0, blink_q};
      2'd2: readdata = {23'd0, phase_q, 1'b0, hex_q};
      default: readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_hex_seg_driver.sv
// Randomized scoreboard bench for hex_seg_driver against an
// arithmetic reference model (cycle counts, not counters).
module tb_hex_seg_driver;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [6:0]  seg_in = '0;
  logic [6:0]  hex_n;

  hex_seg_driver dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .seg_in     (seg_in),
    .hex_n      (hex_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  hex;
    logic [31:0] rd;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   tcount = 0;

  logic [6:0] font_tab [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model: edges since reset and since last blink restart
  int         cyc;
  int         rst_cyc;
  int         period;
  bit         m_en, m_ben, m_dec;
  int         m_bright;
  logic [6:0] m_seg;
  logic [6:0] m_hex;

  function automatic bit m_phase();
    int m;
    m = cyc - rst_cyc;
    return ((m / (period + 1)) % 2) == 0;
  endfunction

  function automatic logic [31:0] m_read(input logic [1:0] a);
    logic [31:0] r;
    r = 0;
    if (a == 2'd0)
      r = m_bright * 256 + m_dec * 4 + m_ben * 2 + m_en;
    else if (a == 2'd1)
      r = period;
    else if (a == 2'd2)
      r = m_phase() * 256 + m_hex;
    return r;
  endfunction

  task automatic model_reset();
    cyc = 0; rst_cyc = 0; period = 12499999;
    m_en = 1; m_ben = 0; m_dec = 0; m_bright = 15;
    m_seg = 0; m_hex = 7'h7F;
  endtask

  task automatic model_edge();
    bit         lit, wr, restart;
    logic [6:0] shown;
    lit = m_en && m_phase() && ((cyc % 16) <= m_bright);
    shown = lit ? m_seg : 7'h00;
    m_hex = ~shown;
    m_seg = m_dec ? font_tab[seg_in[3:0]] : seg_in;
    wr = chipselect && !write_n;
    restart = !m_ben || (wr && address == 2'd1);
    if (wr && address == 2'd0) begin
      m_en = writedata[0];
      m_ben = writedata[1];
      m_dec = writedata[2];
      m_bright = int'(writedata[11:8]);
    end
    if (wr && address == 2'd1) period = int'(writedata[23:0]);
    cyc++;
    if (restart) rst_cyc = cyc;
  endtask

  task automatic cycle(input logic [1:0] a, input logic cs,
                       input logic wn, input logic [31:0] wd,
                       input logic [6:0] s);
    exp_t e;
    address = a; chipselect = cs; write_n = wn;
    writedata = wd; seg_in = s;
    e.hex = m_hex; e.rd = m_read(a); e.cyc = tcount;
    exp_q.push_back(e);
    @(posedge clk);
    if (reset_n) model_edge();
    #1;
    tcount++;
  endtask

  task automatic idle(input int n, input logic [6:0] s,
                      input logic [1:0] a);
    for (int i = 0; i < n; i++) cycle(a, 1'b0, 1'b1, 0, s);
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d,
                        input logic [6:0] s);
    cycle(a, 1'b1, 1'b0, d, s);
  endtask

  // Monitor: compare every expectation against sampled outputs
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (hex_n !== e.hex) begin
        miscompares++;
        $display("FAIL hex_n cyc=%0d got=%h exp=%h",
                 e.cyc, hex_n, e.hex);
      end
      vectors++;
      if (readdata !== e.rd) begin
        miscompares++;
        $display("FAIL readdata cyc=%0d addr=%0d got=%h exp=%h",
                 e.cyc, address, readdata, e.rd);
      end
    end
  end

  initial begin
    int n;
    logic [31:0] d;
    model_reset();
    @(posedge clk); #1;
    idle(1, 7'h00, 2'd0);
    idle(1, 7'h00, 2'd1);
    idle(1, 7'h00, 2'd2);
    reset_n = 1'b1;

    // raw passthrough
    idle(6, 7'h5B, 2'd2);
    // decode
    wr_reg(2'd0, 32'h0F05, 7'h0A);
    idle(4, 7'h0A, 2'd0);
    idle(4, 7'h0F, 2'd2);
    // brightness 4/16
    wr_reg(2'd0, 32'h0301, 7'h7F);
    idle(40, 7'h7F, 2'd2);
    // blink, then a restart on the terminal-count cycle
    wr_reg(2'd1, 32'd9, 7'h7F);
    wr_reg(2'd0, 32'h0F03, 7'h7F);
    idle(45, 7'h7F, 2'd2);
    n = 0;
    while (((cyc - rst_cyc) % 10) != 9 && n < 20) begin
      idle(1, 7'h7F, 2'd2);
      n++;
    end
    wr_reg(2'd1, 32'd9, 7'h7F);
    idle(30, 7'h7F, 2'd2);
    // BLINK=0 toggles every cycle
    wr_reg(2'd1, 32'd0, 7'h7F);
    idle(6, 7'h7F, 2'd2);
    // asynchronous reset mid-blink
    wr_reg(2'd1, 32'd3, 7'h7F);
    idle(5, 7'h7F, 2'd2);
    reset_n = 1'b0;
    model_reset();
    idle(1, 7'h7F, 2'd0);
    idle(1, 7'h7F, 2'd1);
    idle(1, 7'h7F, 2'd2);
    reset_n = 1'b1;
    idle(3, 7'h3F, 2'd0);
    // disable and addr3
    wr_reg(2'd0, 32'h0F00, 7'h7F);
    idle(3, 7'h7F, 2'd0);
    wr_reg(2'd3, 32'hFFFF_FFFF, 7'h7F);
    idle(1, 7'h7F, 2'd3);
    idle(1, 7'h7F, 2'd0);
    idle(1, 7'h7F, 2'd1);
    wr_reg(2'd0, 32'h0F01, 7'h11);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] a;
      logic [6:0] s;
      a = 2'($urandom_range(0, 3));
      s = 7'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        d = $urandom;
        if (a == 2'd1) d = $urandom_range(0, 7);
        if (a == 2'd0 && $urandom_range(0, 3) != 0) d[0] = 1'b1;
        wr_reg(a, d, s);
      end else if ($urandom_range(0, 499) == 0) begin
        reset_n = 1'b0;
        model_reset();
        idle(2, s, a);
        reset_n = 1'b1;
      end else begin
        cycle(a, 1'($urandom), 1'b1, $urandom, s);
      end
    end

    n = 0;
    while (exp_q.size() > 0 && n < 10) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain left=%0d exp=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
